// File: rtl/pslip_pkg.sv
// pslip_pkg: shared constants, types and helpers for the pSLIP request-side
// scheduler blocks (pri_tie_arb and the round-robin picker).
//   PSLIP_N / PSLIP_P / PSLIP_C : default port count, priority levels, priority width
//   PSLIP_TIMEOUT               : default grant hold limit (optional timeout build)
//   pri_tie_state_t             : request-side controller states
//   ptr_inc()                   : round-robin pointer increment modulo n
package pslip_pkg;

  localparam int PSLIP_N       = 16;
  localparam int PSLIP_P       = 64;
  localparam int PSLIP_C       = $clog2(PSLIP_P);
  localparam int PSLIP_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_ARB,
    ST_GRANT
  } pri_tie_state_t;

  // Explicit wrap so n need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/pri_tie_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set bit of tie at or above ptr, wrapping modulo N.
//   tie    : request/tie vector
//   ptr    : round-robin start position (must be < N)
//   onehot : one-hot of the chosen bit (all zero when tie is empty)
//   idx    : index of the chosen bit (0 when tie is empty)
// The vector is duplicated and the lower copy masked below ptr; a plain
// lowest-index encode over the 2N-bit result then yields the wrapped winner,
// since upper-copy bits stand in for indices that come "after" N-1.
module rr_pick
  import pslip_pkg::*;
#(
  parameter  int N  = PSLIP_N,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  tie,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mdbl;
  logic           found;
  int             pos;

  always_comb begin
    dbl   = {tie, tie};
    mdbl  = '0;
    found = 1'b0;
    pos   = 0;
    for (int j = 0; j < 2*N; j++)
      mdbl[j] = dbl[j] & (j >= int'(ptr));
    for (int j = 0; j < 2*N; j++) begin
      if (mdbl[j] && !found) begin
        found = 1'b1;
        pos   = j;
      end
    end
    idx = (pos >= N) ? PW'(pos - N) : PW'(pos);
    for (int k = 0; k < N; k++)
      onehot[k] = found && (idx == PW'(k));
  end

endmodule

// File: rtl/pri_tie_arb.sv
// pri_tie_arb: request-side controller and tie-break arbiter for the pSLIP
// bit-serial priority selector.
// Takes a snapshot of N per-port priorities, launches one selector pass,
// captures the tie vector of ports at the highest priority, and issues a
// single one-hot grant by round-robin. The pointer moves past the winner only
// when the grant is accepted.
// Ports:
//   clk, reset            : clock, async active-high reset
//   req_pri/valid/ready   : snapshot handshake (priority 0 = no request)
//   sel_in, sel_update    : priorities and start pulse to the selector
//   sel_ready, sel_req    : selector result pulse and tie vector
//   gnt, gnt_pri          : registered one-hot grant and its priority
//   gnt_valid, gnt_accept : grant handshake
//   no_req                : pulse when a pass finds no requesting port
// Build option: PRI_TIE_TIMEOUT_EN -- withdraw an unaccepted grant after
// TIMEOUT cycles in GRANT (pointer unchanged). Undefined: hold until accept.
module pri_tie_arb
  import pslip_pkg::*;
#(
  parameter int N       = PSLIP_N,
  parameter int P       = PSLIP_P,
  parameter int C       = $clog2(P),
  parameter int TIMEOUT = PSLIP_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0][C-1:0] req_pri,
  input  logic                req_valid,
  output logic                req_ready,
  output logic [N-1:0][C-1:0] sel_in,
  output logic                sel_update,
  input  logic                sel_ready,
  input  logic [N-1:0]        sel_req,
  output logic [N-1:0]        gnt,
  output logic [C-1:0]        gnt_pri,
  output logic                gnt_valid,
  input  logic                gnt_accept,
  output logic                no_req
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  pri_tie_state_t      state, nstate;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       win_idx;
  logic [N-1:0][C-1:0] snap;
  logic [N-1:0]        tie;
  logic [N-1:0]        pk_onehot;
  logic [PW-1:0]       pk_idx;

`ifdef PRI_TIE_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] to_cnt;
`endif

  // Snapshot stays on the selector bus for the whole pass.
  assign sel_in = snap;

  rr_pick #(.N(N)) u_pick (
    .tie    (tie),
    .ptr    (ptr),
    .onehot (pk_onehot),
    .idx    (pk_idx)
  );

  always_comb begin
    nstate     = state;
    req_ready  = 1'b0;
    sel_update = 1'b0;
    no_req     = 1'b0;
    gnt_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        // State is already IDLE while reset is held; keep ready low until release.
        req_ready = ~reset;
        if (req_valid) nstate = ST_LOAD;
      end
      ST_LOAD: begin
        sel_update = 1'b1;
        nstate     = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_ready) nstate = ST_ARB;
      end
      ST_ARB: begin
        if (tie == '0) begin
          no_req = 1'b1;
          nstate = ST_IDLE;
        end else begin
          nstate = ST_GRANT;
        end
      end
      ST_GRANT: begin
        gnt_valid = 1'b1;
        if (gnt_accept) nstate = ST_IDLE;
`ifdef PRI_TIE_TIMEOUT_EN
        // Accept is tested first so an accept in the last cycle still wins.
        else if (to_cnt == TW'(TIMEOUT - 1)) nstate = ST_IDLE;
`endif
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win_idx <= '0;
      snap    <= '0;
      tie     <= '0;
      gnt     <= '0;
      gnt_pri <= '0;
    end else begin
      state <= nstate;
      if (state == ST_IDLE && req_valid)
        snap <= req_pri;
      // Results outside WAIT are stale passes; drop them.
      if (state == ST_WAIT && sel_ready)
        tie <= sel_req;
      if (state == ST_ARB && tie != '0) begin
        gnt     <= pk_onehot;
        gnt_pri <= snap[pk_idx];
        win_idx <= pk_idx;
      end
      if (state == ST_GRANT && gnt_accept)
        ptr <= PW'(ptr_inc(int'(win_idx), N));
    end
  end

`ifdef PRI_TIE_TIMEOUT_EN
  // Counts completed GRANT cycles; zero on GRANT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 to_cnt <= '0;
    else if (state != ST_GRANT) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pri_tie_arb.sv
// tb_pri_tie_arb: randomized + directed scoreboard bench for pri_tie_arb.
// The driver computes each expected outcome from a behavioural model (highest
// priority set, round-robin scan from a model pointer) and queues it; the
// monitor pops and compares on each grant offer or no_req pulse, including
// the cycle it appears in. A selector model answers each sel_update seven
// cycles later with the tie vector of the highest nonzero priority.
module tb_pri_tie_arb;

  localparam int N  = 16;
  localparam int C  = 6;
  localparam int TO = 15;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0][C-1:0] req_pri = '0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [N-1:0][C-1:0] sel_in;
  logic                sel_update;
  logic                sel_ready = 1'b0;
  logic [N-1:0]        sel_req = '0;
  logic [N-1:0]        gnt;
  logic [C-1:0]        gnt_pri;
  logic                gnt_valid;
  logic                gnt_accept = 1'b0;
  logic                no_req;

  pri_tie_arb #(.N(N), .P(64), .C(C), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_pri    (req_pri),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .sel_in     (sel_in),
    .sel_update (sel_update),
    .sel_ready  (sel_ready),
    .sel_req    (sel_req),
    .gnt        (gnt),
    .gnt_pri    (gnt_pri),
    .gnt_valid  (gnt_valid),
    .gnt_accept (gnt_accept),
    .no_req     (no_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           nr;
    logic [N-1:0] g;
    logic [C-1:0] p;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mptr   = 0;
  int   sel_pulses = 0;
  logic [N-1:0][C-1:0] snap_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Selector model: result pulse seven cycles after the update cycle.
  int           pend = 0;
  logic [N-1:0] pend_tie;
  always @(negedge clk) begin
    int mx;
    sel_ready = 1'b0;
    if (sel_update) begin
      chk("sel_in_snapshot", 32'(sel_in == snap_exp), 1);
      mx = 0;
      for (int i = 0; i < N; i++) if (int'(sel_in[i]) > mx) mx = int'(sel_in[i]);
      pend_tie = '0;
      for (int i = 0; i < N; i++) pend_tie[i] = (mx != 0) && (int'(sel_in[i]) == mx);
      pend = 7;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        sel_ready = 1'b1;
        sel_req   = pend_tie;
        sel_pulses++;
      end
    end
  end

  // Monitor / scoreboard.
  logic         gv_prev = 1'b0;
  logic [N-1:0] g_held;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (no_req) begin
        if (exp_q.size() == 0) chk("unexpected_no_req", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("no_req_kind", 32'(e.nr), 1);
          chk("no_req_cycle", cyc, e.cyc);
        end
      end
      if (gnt_valid && !gv_prev) begin
        if (exp_q.size() == 0) chk("unexpected_gnt_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("gnt_kind", 32'(e.nr), 0);
          chk("gnt", 32'(gnt), 32'(e.g));
          chk("gnt_pri", 32'(gnt_pri), 32'(e.p));
          chk("gnt_cycle", cyc, e.cyc);
        end
        g_held = gnt;
      end else if (gnt_valid) begin
        if (gnt !== g_held) chk("gnt_stable", 32'(gnt), 32'(g_held));
      end
    end
    gv_prev = gnt_valid & ~reset;
  end

  // One snapshot through to grant/no_req. acc_dly < 0: never accept.
  task automatic run_pass(input logic [N-1:0][C-1:0] pri, input int acc_dly);
    int   w, mx, win, t, n;
    exp_t e;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk("req_ready_before_pass", 32'(req_ready), 1);
    t = cyc;
    req_pri   = pri;
    req_valid = 1'b1;
    snap_exp  = pri;
    mx = 0;
    for (int i = 0; i < N; i++) if (int'(pri[i]) > mx) mx = int'(pri[i]);
    win = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (int'(pri[i]) == mx) begin win = i; break; end
    end
    e.nr  = (mx == 0);
    e.g   = (mx == 0) ? '0 : (N'(1) << win);
    e.p   = C'(mx);
    e.cyc = (mx == 0) ? t + 9 : t + 10;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < N; i++) req_pri[i] = C'($urandom);  // must not disturb the snapshot
    w = 0;
    while (!(gnt_valid || no_req) && w < 30) begin @(negedge clk); w++; end
    if (!(gnt_valid || no_req)) begin
      chk("response_timeout", 0, 1);
      return;
    end
    if (mx == 0) begin
      @(negedge clk);
      chk("ready_after_no_req", 32'(req_ready), 1);
      chk("no_grant_after_no_req", 32'(gnt_valid), 0);
      return;
    end
    if (acc_dly < 0) begin
      n = 0;
      while (gnt_valid && n < 100) begin @(negedge clk); n++; end
      chk("timeout_len", n, TO);
      chk("ready_after_timeout", 32'(req_ready), 1);
      return;
    end
    repeat (acc_dly) @(negedge clk);
    chk("grant_held", 32'(gnt_valid), 1);
    gnt_accept = 1'b1;
    @(negedge clk);
    gnt_accept = 1'b0;
    mptr = (win + 1) % N;
    chk("ready_after_accept", 32'(req_ready), 1);
    chk("gnt_valid_after_accept", 32'(gnt_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][C-1:0] p;
    int sp;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_gnt_valid", 32'(gnt_valid), 0);
    chk("rst_sel_update", 32'(sel_update), 0);
    chk("rst_no_req", 32'(no_req), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gnt_pri", 32'(gnt_pri), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", 32'(req_ready), 1);

    // Single winner: port 5 at 33; then a 4/6 tie proves ptr moved to 6.
    p = '0; p[5] = 6'd33;
    run_pass(p, 0);
    p = '0; p[4] = 6'd20; p[6] = 6'd20;
    run_pass(p, 1);                                  // expects 6, ptr -> 7

    // Tie rotation from ptr 0 after a reset.
    reset = 1'b1; @(negedge clk); reset = 1'b0; mptr = 0;
    @(negedge clk);
    p = '0; p[3] = 6'd40; p[7] = 6'd40; p[9] = 6'd12;
    run_pass(p, 0);                                  // 3
    run_pass(p, 2);                                  // 7
    run_pass(p, 0);                                  // wraps to 3

    // Wrap at top: move ptr to 15, then tie {0,15}.
    p = '0; p[14] = 6'd5;
    run_pass(p, 0);                                  // ptr -> 15
    p = '0; p[0] = 6'd63; p[15] = 6'd63;
    run_pass(p, 0);                                  // 15, ptr -> 0
    run_pass(p, 0);                                  // 0

    // All-zero snapshot.
    p = '0;
    run_pass(p, 0);

`ifdef PRI_TIE_TIMEOUT_EN
    p = '0; p[2] = 6'd9; p[11] = 6'd9;
    run_pass(p, -1);                                 // withdrawn, ptr unchanged
    run_pass(p, 0);                                  // same winner again
`else
    p = '0; p[2] = 6'd9; p[11] = 6'd9;
    run_pass(p, 40);                                 // grant held until accept
`endif

    // Reset during WAIT; the selector's stale result must be ignored.
    p = '0; p[8] = 6'd17;
    while (!req_ready) @(negedge clk);
    req_pri = p; snap_exp = p; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    sp = sel_pulses;
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_sel_update", 32'(sel_update), 0);
    chk("midrst_gnt_valid", 32'(gnt_valid), 0);
    chk("midrst_no_req", 32'(no_req), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_sel_in", 32'(sel_in == '0), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0; mptr = 0;
    begin
      int w;
      w = 0;
      while (sel_pulses == sp && w < 20) begin @(negedge clk); w++; end
      chk("stale_sel_ready_seen", 32'(sel_pulses != sp), 1);
    end
    repeat (5) @(negedge clk);
    chk("no_grant_from_stale", 32'(gnt_valid), 0);
    chk("ready_after_stale", 32'(req_ready), 1);
    run_pass(p, 0);

    // Randomized passes.
    for (int r = 0; r < 40; r++) begin
      int lvl;
      lvl = ($urandom_range(0, 1) == 0) ? 3 : 63;
      for (int i = 0; i < N; i++)
        p[i] = ($urandom_range(0, 2) == 0) ? C'(0) : C'($urandom_range(1, lvl));
      if ($urandom_range(0, 7) == 0) p = '0;
      run_pass(p, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
